// File: rtl/fetch_pc_unit.sv
// LEGv8 instruction-fetch / next-PC stage.
// Holds the PC, fetches over req/ack and resolves the next PC on retire.
module fetch_pc_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] Instruction,
    output logic [25:0] Imm25,
    output logic [63:0] PC,
    input  logic        Branch,
    input  logic        Uncondbranch,
    input  logic        Zero,
    input  logic [63:0] BusImm,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_FAULT
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        take;
    logic [63:0] imm_off;
    logic [63:0] next_pc;

    assign take      = Uncondbranch | (Branch & Zero);
    assign imm_off   = BusImm << 2;
    assign next_pc   = take ? PC + imm_off : PC + 64'd4;
    assign imem_addr = PC;
    assign Imm25     = Instruction[25:0];

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state       <= S_IDLE;
            PC          <= RESET_PC;
            imem_req    <= 1'b0;
            inst_valid  <= 1'b0;
            Instruction <= 32'h0;
            fetch_fault <= 1'b0;
            wait_cnt    <= 8'h0;
        end else begin
            case (state)
                // Any ack seen here belongs to a request issued before reset.
                S_IDLE: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                    wait_cnt <= 8'h0;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        Instruction <= imem_rdata;
                        inst_valid  <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= S_HOLD;
                    end else if (wait_cnt + 8'd1 == WAIT_LIMIT) begin
                        wait_cnt    <= WAIT_LIMIT;
                        fetch_fault <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= S_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        PC         <= next_pc;
                        inst_valid <= 1'b0;
                        wait_cnt   <= 8'h0;
                        imem_req   <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_FAULT: begin
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                end
                default: begin
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                    state      <= S_FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: memory responder, retire scoreboard, directed steps.
// MAX_WAIT is set to 4 so the ack timeout is reachable quickly.
module tb_fetch_pc_unit;

    localparam int          MAX_WAIT = 4;
    localparam logic [63:0] RST_PC   = 64'h0;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] Instruction;
    logic [25:0] Imm25;
    logic [63:0] PC;
    logic        Branch = 1'b0;
    logic        Uncondbranch = 1'b0;
    logic        Zero = 1'b0;
    logic [63:0] BusImm = 64'h0;
    logic        fetch_fault;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] model_pc = RST_PC;
    int          cyc = 0;
    int          last_retire = 0;
    logic        mem_en = 1'b0;
    int          mem_delay = 1;
    int          dly_cnt = 0;
    int          inj_seq = 0;
    int          inj_done = 0;
    logic [31:0] inj_data = 32'h0;

    fetch_pc_unit #(
        .RESET_PC(RST_PC),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .CLK(CLK),
        .Reset(Reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .Instruction(Instruction),
        .Imm25(Imm25),
        .PC(PC),
        .Branch(Branch),
        .Uncondbranch(Uncondbranch),
        .Zero(Zero),
        .BusImm(BusImm),
        .fetch_fault(fetch_fault)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        if (a == 64'h8) return 32'h17FF_FFFF;
        return a[31:0] ^ 32'h8C3A_51E7;
    endfunction

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Memory responder: answers mem_delay cycles after it first sees req.
    always begin
        @(posedge CLK);
        #2;
        if (inj_seq != inj_done) begin
            inj_done   = inj_seq;
            imem_ack   = 1'b1;
            imem_rdata = inj_data;
            dly_cnt    = 0;
        end else if (mem_en && imem_req && !Reset) begin
            if (dly_cnt >= mem_delay) begin
                check("req_addr", imem_addr, model_pc);
                imem_rdata = word_of(imem_addr);
                imem_ack   = 1'b1;
                sb_q.push_back('{pc: imem_addr, word: imem_rdata});
                dly_cnt    = 0;
            end else begin
                imem_ack = 1'b0;
                dly_cnt++;
            end
        end else begin
            imem_ack = 1'b0;
            dly_cnt  = 0;
        end
    end

    // Retire monitor: compares the held instruction and advances the model PC.
    always @(negedge CLK) begin
        if (Reset) begin
            model_pc = RST_PC;
        end else if (inst_valid && inst_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("ret_pc", PC, e.pc);
                check("ret_inst", Instruction, e.word);
                check("ret_imm25", Imm25, e.word[25:0]);
            end
            if (Uncondbranch | (Branch & Zero))
                model_pc = model_pc + (BusImm << 2);
            else
                model_pc = model_pc + 64'd4;
        end
    end

    task automatic wait_valid();
        int n = 0;
        while (!inst_valid && n < 50) begin
            tick();
            n++;
        end
        check("valid_timeout", inst_valid, 1);
    endtask

    task automatic expect_req(input logic [63:0] addr);
        int n = 0;
        while (!imem_req && n < 50) begin
            tick();
            n++;
        end
        check("req_seen", imem_req, 1);
        check("req_addr_lit", imem_addr, addr);
    endtask

    task automatic step(input logic br, input logic ub, input logic z,
                        input logic [63:0] imm, input int hold,
                        input logic [63:0] next_addr);
        logic [122:0] snap;
        wait_valid();
        Branch       = br;
        Uncondbranch = ub;
        Zero         = z;
        BusImm       = imm;
        snap = {inst_valid, Instruction, Imm25, PC};
        repeat (hold) begin
            tick();
            check("hold_stable", {inst_valid, Instruction, Imm25, PC}, snap);
        end
        inst_ready = 1'b1;
        tick();
        last_retire  = cyc;
        inst_ready   = 1'b0;
        Branch       = 1'b0;
        Uncondbranch = 1'b0;
        Zero         = 1'b0;
        BusImm       = 64'h0;
        expect_req(next_addr);
    endtask

    initial begin
        int t0;
        tick(3);
        check("rst_req", imem_req, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_inst", Instruction, 0);
        check("rst_pc", PC, RST_PC);
        check("rst_fault", fetch_fault, 0);

        // Reset mid-fetch, then a stale ack during the IDLE cycle
        Reset = 1'b0;
        tick(3);
        check("fetch_req", imem_req, 1);
        Reset = 1'b1;
        #1;
        check("async_rst_req", imem_req, 0);
        tick(2);
        Reset    = 1'b0;
        inj_data = 32'hDEAD_BEEF;
        inj_seq++;
        tick();
        check("idle_ack_req", imem_req, 1);
        check("idle_ack_addr", imem_addr, RST_PC);
        check("idle_ack_valid", inst_valid, 0);
        check("idle_ack_inst", Instruction, 0);

        // Sequential stream, 1-cycle ack
        mem_en    = 1'b1;
        mem_delay = 1;
        step(0, 0, 0, 64'h0, 0, 64'h4);
        t0 = last_retire;
        step(0, 0, 0, 64'h0, 0, 64'h8);
        check("thruput_1", last_retire - t0, 3);
        t0 = last_retire;
        step(0, 0, 0, 64'h0, 0, 64'hC);
        check("thruput_2", last_retire - t0, 3);

        // Branches
        step(0, 1, 0, 64'h3D, 0, 64'h100);
        step(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 64'hF8);
        step(0, 1, 0, 64'h2, 0, 64'h100);
        step(1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 64'h104);
        step(1, 1, 0, 64'hFFFF_FFFF_FFFF_FFBE, 0, 64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 1, 0, 64'h3, 5, 64'h8);

        // Imm25 from the fetched word at 0x8
        wait_valid();
        check("imm25_lit", Imm25, 26'h3FF_FFFF);
        check("inst_lit", Instruction, 32'h17FF_FFFF);

        // Ack timeout
        mem_en = 1'b0;
        step(0, 0, 0, 64'h0, 0, 64'hC);
        tick(3);
        check("pre_fault_req", imem_req, 1);
        check("pre_fault_flag", fetch_fault, 0);
        tick();
        check("fault_flag", fetch_fault, 1);
        check("fault_req", imem_req, 0);
        inj_data = 32'h1234_5678;
        inj_seq++;
        tick(3);
        check("fault_valid", inst_valid, 0);
        check("fault_req_late", imem_req, 0);
        check("fault_sticky", fetch_fault, 1);
        check("fault_pc", PC, 64'hC);
        Reset = 1'b1;
        #1;
        check("fault_clr", fetch_fault, 0);
        check("fault_rst_pc", PC, RST_PC);
        tick();
        Reset  = 1'b0;
        mem_en = 1'b1;
        expect_req(RST_PC);
        step(0, 0, 0, 64'h0, 0, 64'h4);
        check("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
